// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with saturating load, clear, wrap pulse and
// a leading-zero mask for the downstream seven-segment display stage.
module bcd_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    count_enable,
  input  logic                    count_up,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    rollover_flag,
  output logic [NUM_DIGITS-1:0]   lz_mask
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0]        r_digits;
  logic                r_rollover;
  logic [W-1:0]        w_next_digits;
  // w_chain[i]=1 when every digit below i is at its wrap value, so digit i steps
  logic [NUM_DIGITS:0] w_chain;
  logic                w_wrap;

  assign w_chain[0] = 1'b1;
  assign w_wrap     = count_enable & ~clear & ~load & w_chain[NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] w_cur;
      logic [3:0] w_ld;
      logic [3:0] w_ld_sat;
      logic [3:0] w_step;

      assign w_cur    = r_digits[4*gi +: 4];
      assign w_ld     = load_value[4*gi +: 4];
      assign w_ld_sat = (w_ld > 4'd9) ? 4'd9 : w_ld;
      assign w_step   = count_up ? ((w_cur == 4'd9) ? 4'd0 : w_cur + 4'd1)
                                 : ((w_cur == 4'd0) ? 4'd9 : w_cur - 4'd1);

      assign w_chain[gi+1] = w_chain[gi] &
                             (count_up ? (w_cur == 4'd9) : (w_cur == 4'd0));

      assign w_next_digits[4*gi +: 4] =
        clear                         ? 4'd0     :
        load                          ? w_ld_sat :
        (count_enable && w_chain[gi]) ? w_step   : w_cur;

      // digit 0 is never blanked so a zero count still shows one digit
      if (gi == 0) begin : g_lz0
        assign lz_mask[gi] = 1'b0;
      end else begin : g_lzn
        assign lz_mask[gi] = (r_digits[W-1:4*gi] == '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_digits   <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_digits   <= w_next_digits;
      r_rollover <= w_wrap;
    end
  end

  assign digits        = r_digits;
  assign rollover_flag = r_rollover;
endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: vector table through a scoreboard queue,
// plus async-reset and single-digit back-to-back wrap sequences.
module tb_bcd_counter;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear, load, count_enable, count_up;
  logic [15:0] load_value;
  logic [15:0] digits;
  logic        rollover_flag;
  logic [3:0]  lz_mask;

  logic        c1_clear, c1_load, c1_en, c1_up;
  logic [3:0]  c1_load_value;
  logic [3:0]  c1_digits;
  logic        c1_flag;
  logic [0:0]  c1_lz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        clr;
    logic        ld;
    logic [15:0] lv;
    logic        en;
    logic        up;
    logic [15:0] e_dig;
    logic        e_flag;
    logic [3:0]  e_lz;
  } vec_t;

  typedef struct {
    logic [15:0] dig;
    logic        flag;
    logic [3:0]  lz;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[19];

  always #5 clk = ~clk;

  bcd_counter #(.NUM_DIGITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
    .load_value(load_value), .count_enable(count_enable), .count_up(count_up),
    .digits(digits), .rollover_flag(rollover_flag), .lz_mask(lz_mask)
  );

  bcd_counter #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .clear(c1_clear), .load(c1_load),
    .load_value(c1_load_value), .count_enable(c1_en), .count_up(c1_up),
    .digits(c1_digits), .rollover_flag(c1_flag), .lz_mask(c1_lz)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [15:0] dig,
                          input logic flag, input logic [3:0] lz);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".digits"}, 32'(dig), 32'(e.dig));
    cmp({tag, ".flag"}, 32'(flag), 32'(e.flag));
    cmp({tag, ".lz"}, 32'(lz), 32'(e.lz));
    $display("%s: digits=%h flag=%0b lz=%b exp digits=%h flag=%0b lz=%b",
             tag, dig, flag, lz, e.dig, e.flag, e.lz);
  endtask

  task automatic apply4(input vec_t v, input int idx);
    exp_t e;
    clear = v.clr; load = v.ld; load_value = v.lv;
    count_enable = v.en; count_up = v.up;
    e.dig = v.e_dig; e.flag = v.e_flag; e.lz = v.e_lz;
    sb.push_back(e);
    @(posedge clk); #1;
    check_sb($sformatf("vec%0d", idx), digits, rollover_flag, lz_mask);
  endtask

  initial begin
    // clr ld  lv       en up   digits   flag lz
    vecs[0]  = '{0, 1, 16'h0199, 0, 0, 16'h0199, 0, 4'b1000};
    vecs[1]  = '{0, 0, 16'h0000, 1, 1, 16'h0200, 0, 4'b1000};
    vecs[2]  = '{0, 1, 16'h9999, 0, 1, 16'h9999, 0, 4'b0000};
    vecs[3]  = '{0, 0, 16'h0000, 1, 1, 16'h0000, 1, 4'b1110};
    vecs[4]  = '{0, 0, 16'h0000, 1, 1, 16'h0001, 0, 4'b1110};
    vecs[5]  = '{0, 0, 16'h5555, 0, 1, 16'h0001, 0, 4'b1110};
    vecs[6]  = '{0, 1, 16'h0100, 0, 0, 16'h0100, 0, 4'b1000};
    vecs[7]  = '{0, 0, 16'h0000, 1, 0, 16'h0099, 0, 4'b1100};
    vecs[8]  = '{0, 1, 16'h0000, 0, 0, 16'h0000, 0, 4'b1110};
    vecs[9]  = '{0, 0, 16'h0000, 1, 0, 16'h9999, 1, 4'b0000};
    vecs[10] = '{0, 0, 16'h0000, 0, 0, 16'h9999, 0, 4'b0000};
    vecs[11] = '{1, 1, 16'h1234, 1, 1, 16'h0000, 0, 4'b1110};
    vecs[12] = '{0, 1, 16'h3AF7, 1, 1, 16'h3997, 0, 4'b0000};
    vecs[13] = '{0, 1, 16'h9999, 0, 1, 16'h9999, 0, 4'b0000};
    vecs[14] = '{0, 1, 16'h9999, 1, 1, 16'h9999, 0, 4'b0000};
    vecs[15] = '{1, 0, 16'h0000, 1, 1, 16'h0000, 0, 4'b1110};
    vecs[16] = '{0, 1, 16'h00A0, 0, 1, 16'h0090, 0, 4'b1100};
    vecs[17] = '{0, 0, 16'h0000, 1, 0, 16'h0089, 0, 4'b1100};
    vecs[18] = '{0, 0, 16'h0000, 1, 1, 16'h0090, 0, 4'b1100};

    n_rst = 1'b0;
    clear = 0; load = 0; load_value = '0; count_enable = 0; count_up = 0;
    c1_clear = 0; c1_load = 0; c1_load_value = '0; c1_en = 0; c1_up = 1;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.digits", 32'(digits), 32'h0000);
    cmp("reset.flag", 32'(rollover_flag), 32'd0);
    cmp("reset.lz", 32'(lz_mask), 32'(4'b1110));
    cmp("reset.d1", 32'(c1_digits), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 19; i++) apply4(vecs[i], i);

    // asynchronous reset mid-cycle, then count resumes from zero
    clear = 0; load = 1; load_value = 16'h4567; count_enable = 0;
    @(posedge clk); #1;
    cmp("preload.digits", 32'(digits), 32'h4567);
    load = 0;
    #2;
    n_rst = 1'b0;
    #1;
    cmp("async_rst.digits", 32'(digits), 32'h0000);
    cmp("async_rst.flag", 32'(rollover_flag), 32'd0);
    cmp("async_rst.lz", 32'(lz_mask), 32'(4'b1110));
    @(negedge clk);
    n_rst = 1'b1;
    begin
      vec_t v;
      v = '{0, 0, 16'h0000, 1, 1, 16'h0001, 0, 4'b1110};
      apply4(v, 100);
    end
    count_enable = 0;

    // single digit with enable held: wraps on cycles 10 and 20
    c1_en = 1'b1; c1_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      cmp($sformatf("nd1.c%0d.digit", k), 32'(c1_digits), 32'(k % 10));
      cmp($sformatf("nd1.c%0d.flag", k), 32'(c1_flag), 32'((k == 10) || (k == 20)));
      cmp($sformatf("nd1.c%0d.lz", k), 32'(c1_lz), 32'd0);
      $display("nd1 cycle %0d: digit=%0d flag=%0b", k, c1_digits, c1_flag);
    end
    c1_en = 1'b0;
    @(posedge clk); #1;
    cmp("nd1.hold.flag", 32'(c1_flag), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
